// File: rtl/adpll_cfg_seq_pkg.sv
// Shared ADPLL defines: bus geometry, register map and sequencer state encodings.
package adpll_cfg_seq_pkg;

  localparam int ADDR_W = 5;
  localparam int FCWW   = 26;

  localparam logic [ADDR_W-1:0] ADPLL_SOFT_RST = 5'h00;
  localparam logic [ADDR_W-1:0] FCW            = 5'h01;
  localparam logic [ADDR_W-1:0] ADPLL_MODE     = 5'h02;
  localparam logic [ADDR_W-1:0] ADPLL_EN       = 5'h03;
  localparam logic [ADDR_W-1:0] ADPLL_LOCK     = 5'h04;
  localparam logic [ADDR_W-1:0] ADPLL_SAT      = 5'h05;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_WR_RST  = 4'd1,
    S_WR_FCW  = 4'd2,
    S_WR_MODE = 4'd3,
    S_WR_EN   = 4'd4,
    S_RD_LOCK = 4'd5,
    S_WAIT    = 4'd6,
    S_RD_SAT  = 4'd7,
    S_FIN     = 4'd8
  } seq_state_t;

  typedef enum logic [1:0] {
    BM_IDLE = 2'd0,
    BM_REQ  = 2'd1,
    BM_GAP  = 2'd2
  } bm_phase_t;

endpackage

// File: rtl/adpll_cfg_seq_bus.sv
// adpll_bus_master: one register access per launch -- request until ready, then one idle gap cycle.
module adpll_bus_master #(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_launch,
  input  logic          i_abort,
  input  logic          i_wr,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  input  logic [31:0]   i_rdata,
  input  logic          i_ready,
  output logic          o_valid,
  output logic          o_wstrb,
  output logic [AW-1:0] o_address,
  output logic [31:0]   o_wdata,
  output logic          o_done,
  output logic          o_rbit
);
  import adpll_cfg_seq_pkg::*;

  bm_phase_t     r_phase;
  logic          r_valid;
  logic          r_wstrb;
  logic [AW-1:0] r_address;
  logic [31:0]   r_wdata;
  logic          r_rbit;

  // A new launch may be accepted while idle or in the gap cycle so back-to-back accesses cost 3 cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase   <= BM_IDLE;
      r_valid   <= 1'b0;
      r_wstrb   <= 1'b0;
      r_address <= '0;
      r_wdata   <= 32'd0;
      r_rbit    <= 1'b0;
    end else if (i_abort) begin
      r_phase <= BM_IDLE;
      r_valid <= 1'b0;
    end else begin
      case (r_phase)
        BM_IDLE, BM_GAP: begin
          if (i_launch) begin
            r_phase   <= BM_REQ;
            r_valid   <= 1'b1;
            r_wstrb   <= i_wr;
            r_address <= i_addr;
            r_wdata   <= i_wdata;
          end else begin
            r_phase <= BM_IDLE;
          end
        end
        BM_REQ: begin
          if (i_ready) begin
            r_phase <= BM_GAP;
            r_valid <= 1'b0;
            r_rbit  <= i_rdata[0];
          end
        end
        default: begin
          r_phase <= BM_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_valid   = r_valid;
  assign o_wstrb   = r_wstrb;
  assign o_address = r_address;
  assign o_wdata   = r_wdata;
  assign o_done    = (r_phase == BM_GAP);
  assign o_rbit    = r_rbit;

endmodule

// File: rtl/adpll_cfg_seq.sv
// ADPLL configuration sequencer: reset, program FCW/mode, enable, poll for lock, read saturation flag.
module adpll_cfg_seq #(
  parameter int ADDR_W   = adpll_cfg_seq_pkg::ADDR_W,
  parameter int FCWW     = adpll_cfg_seq_pkg::FCWW,
  parameter int POLL_MAX = 255,
  parameter int POLL_GAP = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [FCWW-1:0]   fcw_in,
  input  logic [1:0]        mode_in,
  output logic              busy,
  output logic              done,
  output logic              locked,
  output logic              timeout,
  output logic              sat,
  output logic              m_valid,
  output logic [ADDR_W-1:0] m_address,
  output logic [31:0]       m_wdata,
  output logic              m_wstrb,
  input  logic [31:0]       m_rdata,
  input  logic              m_ready
);
  import adpll_cfg_seq_pkg::*;

  localparam int CW = $clog2(POLL_MAX + 1);
  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [CW-1:0] POLL_LAST = CW'(POLL_MAX);

  seq_state_t        r_state;
  logic [FCWW-1:0]   r_fcw;
  logic [1:0]        r_mode;
  logic [CW-1:0]     r_poll_cnt;
  logic [GW-1:0]     r_wait_cnt;
  logic              r_done;
  logic              r_locked;
  logic              r_timeout;
  logic              r_sat;

  logic              w_launch;
  logic              w_wr;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata;
  logic              w_bm_done;
  logic              w_rbit;
  logic              w_wait_exp;
  logic              w_poll_last;

  assign w_wait_exp  = ((32'(r_wait_cnt) + 32'd1) >= 32'(POLL_GAP));
  assign w_poll_last = ((32'(r_poll_cnt) + 32'd1) >= 32'(POLL_MAX));

  // Launch the next access on the same edge the FSM enters its state, so m_valid rises with it.
  always_comb begin
    w_launch = 1'b0;
    w_wr     = 1'b0;
    w_addr   = ADDR_W'(ADPLL_SOFT_RST);
    w_wdata  = 32'd0;
    if (abort) begin
      w_launch = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_launch = start;
          w_wr     = 1'b1;
          w_addr   = ADDR_W'(ADPLL_SOFT_RST);
          w_wdata  = 32'd1;
        end
        S_WR_RST: begin
          w_launch = w_bm_done;
          w_wr     = 1'b1;
          w_addr   = ADDR_W'(FCW);
          w_wdata  = 32'(r_fcw);
        end
        S_WR_FCW: begin
          w_launch = w_bm_done;
          w_wr     = 1'b1;
          w_addr   = ADDR_W'(ADPLL_MODE);
          w_wdata  = {30'd0, r_mode};
        end
        S_WR_MODE: begin
          w_launch = w_bm_done;
          w_wr     = 1'b1;
          w_addr   = ADDR_W'(ADPLL_EN);
          w_wdata  = 32'd1;
        end
        S_WR_EN: begin
          w_launch = w_bm_done;
          w_addr   = ADDR_W'(ADPLL_LOCK);
        end
        S_RD_LOCK: begin
          w_launch = w_bm_done & w_rbit;
          w_addr   = ADDR_W'(ADPLL_SAT);
        end
        S_WAIT: begin
          w_launch = w_wait_exp;
          w_addr   = ADDR_W'(ADPLL_LOCK);
        end
        default: begin
          w_launch = 1'b0;
        end
      endcase
    end
  end

  // Sequencer FSM; done/timeout are set on the edge into FIN so they are visible during FIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_fcw      <= '0;
      r_mode     <= 2'd0;
      r_poll_cnt <= '0;
      r_wait_cnt <= '0;
      r_done     <= 1'b0;
      r_locked   <= 1'b0;
      r_timeout  <= 1'b0;
      r_sat      <= 1'b0;
    end else if (abort) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_fcw      <= fcw_in;
            r_mode     <= mode_in;
            r_locked   <= 1'b0;
            r_timeout  <= 1'b0;
            r_sat      <= 1'b0;
            r_poll_cnt <= '0;
            r_state    <= S_WR_RST;
          end
        end
        S_WR_RST:  if (w_bm_done) r_state <= S_WR_FCW;
        S_WR_FCW:  if (w_bm_done) r_state <= S_WR_MODE;
        S_WR_MODE: if (w_bm_done) r_state <= S_WR_EN;
        S_WR_EN:   if (w_bm_done) r_state <= S_RD_LOCK;
        S_RD_LOCK: begin
          if (w_bm_done) begin
            if (r_poll_cnt != POLL_LAST) r_poll_cnt <= r_poll_cnt + CW'(1);
            if (w_rbit) begin
              r_state <= S_RD_SAT;
            end else if (w_poll_last) begin
              r_timeout <= 1'b1;
              r_done    <= 1'b1;
              r_state   <= S_FIN;
            end else begin
              r_wait_cnt <= '0;
              r_state    <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (w_wait_exp) r_state <= S_RD_LOCK;
          else r_wait_cnt <= r_wait_cnt + GW'(1);
        end
        S_RD_SAT: begin
          if (w_bm_done) begin
            r_sat    <= w_rbit;
            r_locked <= 1'b1;
            r_done   <= 1'b1;
            r_state  <= S_FIN;
          end
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  adpll_bus_master #(.AW(ADDR_W)) u_bus (
    .clk       (clk),
    .rst       (rst),
    .i_launch  (w_launch),
    .i_abort   (abort),
    .i_wr      (w_wr),
    .i_addr    (w_addr),
    .i_wdata   (w_wdata),
    .i_rdata   (m_rdata),
    .i_ready   (m_ready),
    .o_valid   (m_valid),
    .o_wstrb   (m_wstrb),
    .o_address (m_address),
    .o_wdata   (m_wdata),
    .o_done    (w_bm_done),
    .o_rbit    (w_rbit)
  );

  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;
  assign locked  = r_locked;
  assign timeout = r_timeout;
  assign sat     = r_sat;

endmodule

// File: tb/tb_adpll_cfg_seq.sv
// Directed bench for adpll_cfg_seq with a register responder whose ready follows valid by a set delay.
module tb_adpll_cfg_seq;
  import adpll_cfg_seq_pkg::*;

  logic              clk = 1'b0;
  logic              rst, start, abort;
  logic [25:0]       fcw_in;
  logic [1:0]        mode_in;
  logic              busy, done, locked, timeout, sat;
  logic              m_valid, m_wstrb, m_ready;
  logic [ADDR_W-1:0] m_address;
  logic [31:0]       m_wdata, m_rdata;

  int n_err = 0;
  int n_chk = 0;
  int cyc = 0;

  // responder controls
  logic fcw_slow, sat_val;
  int   lock_base, lock_zeros;
  int   vcnt = 0;

  // monitor state
  logic [ADDR_W-1:0] log_addr [128];
  logic [31:0]       log_wdata[128];
  logic              log_wstrb[128];
  int                log_cyc  [128];
  int n_log = 0, lock_reads = 0, n_done = 0, n_valid = 0, n_fcw_valid = 0, n_unstable = 0;
  logic              prev_hold = 1'b0;
  logic [ADDR_W-1:0] prev_addr;
  logic [31:0]       prev_wdata;
  logic              prev_wstrb;

  always #5 clk = ~clk;

  adpll_cfg_seq #(.POLL_MAX(4), .POLL_GAP(15)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .fcw_in(fcw_in), .mode_in(mode_in),
    .busy(busy), .done(done), .locked(locked), .timeout(timeout), .sat(sat),
    .m_valid(m_valid), .m_address(m_address), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ready(m_ready)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    m_ready = m_valid && (vcnt == ((fcw_slow && m_address == FCW) ? 5 : 1));
    m_rdata = 32'd0;
    if (m_address == ADPLL_LOCK) m_rdata = {31'd0, ((lock_reads - lock_base) > lock_zeros)};
    else if (m_address == ADPLL_SAT) m_rdata = {31'd0, sat_val};
    else m_rdata = 32'd0;
  end

  always @(posedge clk) begin
    if (m_valid && !m_ready) vcnt <= vcnt + 1;
    else vcnt <= 0;
  end

  always @(negedge clk) begin
    if (m_valid && m_ready && n_log < 128) begin
      log_addr[n_log]  <= m_address;
      log_wdata[n_log] <= m_wdata;
      log_wstrb[n_log] <= m_wstrb;
      log_cyc[n_log]   <= cyc;
      n_log <= n_log + 1;
      if (m_address == ADPLL_LOCK) lock_reads <= lock_reads + 1;
    end
    if (done) n_done <= n_done + 1;
    if (m_valid) n_valid <= n_valid + 1;
    if (m_valid && m_address == FCW) n_fcw_valid <= n_fcw_valid + 1;
    if (prev_hold && (!m_valid || m_address != prev_addr || m_wdata != prev_wdata || m_wstrb != prev_wstrb))
      n_unstable <= n_unstable + 1;
    prev_hold  <= m_valid && !m_ready && !abort && !rst;
    prev_addr  <= m_address;
    prev_wdata <= m_wdata;
    prev_wstrb <= m_wstrb;
  end

  task automatic pulse_start(input logic [25:0] f, input logic [1:0] m, output int s);
    @(negedge clk); #1;
    fcw_in = f; mode_in = m; start = 1'b1; s = cyc;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim, output int dc);
    int k;
    dc = -1; k = 0;
    while (k < lim && dc < 0) begin
      @(negedge clk); #1;
      if (done) dc = cyc;
      k++;
    end
    n_chk++;
    if (dc < 0) begin n_err++; $display("FAIL done_wait: no done within %0d cycles", lim); end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; fcw_in = 26'd0; mode_in = 2'd0;
    fcw_slow = 1'b0; sat_val = 1'b0; lock_base = 0; lock_zeros = 0;
    repeat (3) @(negedge clk);
    #1;
    n_chk++;
    if ({m_valid, m_wstrb, busy, done, locked, timeout, sat} !== 7'b0) begin
      n_err++; $display("FAIL reset_flags: got %b expected 0000000", {m_valid, m_wstrb, busy, done, locked, timeout, sat});
    end
    n_chk++;
    if (m_address !== 5'd0 || m_wdata !== 32'd0) begin
      n_err++; $display("FAIL reset_bus: got addr %0h data %0h expected 0 0", m_address, m_wdata);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if (busy !== 1'b0 || m_valid !== 1'b0) begin
      n_err++; $display("FAIL idle_after_reset: got busy %b valid %b expected 0 0", busy, m_valid);
    end
  endtask

  task automatic test_basic();
    int s, dc, base, d0;
    logic [ADDR_W-1:0] ea[6];
    logic [31:0] ed[6];
    logic es[6];
    ea = '{ADPLL_SOFT_RST, FCW, ADPLL_MODE, ADPLL_EN, ADPLL_LOCK, ADPLL_SAT};
    ed = '{32'd1, 32'h02620000, 32'd1, 32'd1, 32'd0, 32'd0};
    es = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    lock_base = lock_reads; lock_zeros = 0; sat_val = 1'b0;
    base = n_log; d0 = n_done;
    pulse_start(26'h2620000, 2'b01, s);
    n_chk++;
    if (busy !== 1'b1 || m_valid !== 1'b1 || m_address !== ADPLL_SOFT_RST) begin
      n_err++; $display("FAIL first_request: got busy %b valid %b addr %0h expected 1 1 0", busy, m_valid, m_address);
    end
    // a second start while busy must not re-latch the channel word
    fcw_in = 26'h1234567; mode_in = 2'b11; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    wait_done(100, dc);
    n_chk++;
    if (dc - s != 19) begin n_err++; $display("FAIL basic_done_cycle: got %0d expected 19", dc - s); end
    n_chk++;
    if (locked !== 1'b1 || timeout !== 1'b0 || sat !== 1'b0) begin
      n_err++; $display("FAIL basic_status: got locked %b timeout %b sat %b expected 1 0 0", locked, timeout, sat);
    end
    n_chk++;
    if (n_log - base != 6) begin n_err++; $display("FAIL basic_txn_count: got %0d expected 6", n_log - base); end
    if (n_log - base >= 6) begin
      for (int k = 0; k < 6; k++) begin
        n_chk++;
        if (log_addr[base+k] !== ea[k] || log_wstrb[base+k] !== es[k] ||
            (es[k] && log_wdata[base+k] !== ed[k]) || log_cyc[base+k] != s + 2 + 3*k) begin
          n_err++;
          $display("FAIL basic_txn%0d: got addr %0h data %0h wstrb %b cyc %0d expected addr %0h data %0h wstrb %b cyc %0d",
                   k, log_addr[base+k], log_wdata[base+k], log_wstrb[base+k], log_cyc[base+k] - s,
                   ea[k], ed[k], es[k], 2 + 3*k);
        end
      end
    end
    @(negedge clk); #1;
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0 || n_done - d0 != 1) begin
      n_err++; $display("FAIL basic_fin: got busy %b done %b pulses %0d expected 0 0 1", busy, done, n_done - d0);
    end
  endtask

  task automatic test_poll_retry();
    int s, dc, base, n_lock, n_sat;
    int lc[4];
    lock_base = lock_reads; lock_zeros = 3; sat_val = 1'b0;
    base = n_log; n_lock = 0; n_sat = 0;
    pulse_start(26'h0155555, 2'b10, s);
    wait_done(200, dc);
    for (int k = base; k < n_log; k++) begin
      if (log_addr[k] == ADPLL_LOCK) begin
        if (n_lock < 4) lc[n_lock] = log_cyc[k];
        n_lock++;
      end
      if (log_addr[k] == ADPLL_SAT) n_sat++;
    end
    n_chk++;
    if (n_lock != 4 || n_sat != 1) begin
      n_err++; $display("FAIL retry_reads: got lock %0d sat %0d expected 4 1", n_lock, n_sat);
    end
    if (n_lock == 4) begin
      for (int i = 1; i < 4; i++) begin
        n_chk++;
        if (lc[i] - lc[i-1] != 18) begin
          n_err++; $display("FAIL retry_spacing%0d: got %0d expected 18", i, lc[i] - lc[i-1]);
        end
      end
    end
    n_chk++;
    if (dc - s != 73 || locked !== 1'b1 || timeout !== 1'b0) begin
      n_err++; $display("FAIL retry_status: got cyc %0d locked %b timeout %b expected 73 1 0", dc - s, locked, timeout);
    end
  endtask

  task automatic test_timeout();
    int s, dc, base, d0, n_lock, n_sat;
    lock_base = lock_reads; lock_zeros = 1000;
    base = n_log; d0 = n_done; n_lock = 0; n_sat = 0;
    pulse_start(26'h0000001, 2'b00, s);
    wait_done(200, dc);
    n_chk++;
    if (dc - s != 70 || timeout !== 1'b1 || locked !== 1'b0) begin
      n_err++; $display("FAIL timeout_status: got cyc %0d timeout %b locked %b expected 70 1 0", dc - s, timeout, locked);
    end
    repeat (5) @(negedge clk);
    #1;
    for (int k = base; k < n_log; k++) begin
      if (log_addr[k] == ADPLL_LOCK) n_lock++;
      if (log_addr[k] == ADPLL_SAT) n_sat++;
    end
    n_chk++;
    if (n_lock != 4 || n_sat != 0 || n_done - d0 != 1 || busy !== 1'b0) begin
      n_err++; $display("FAIL timeout_reads: got lock %0d sat %0d pulses %0d busy %b expected 4 0 1 0",
                        n_lock, n_sat, n_done - d0, busy);
    end
  endtask

  task automatic test_sat();
    int s, dc;
    lock_base = lock_reads; lock_zeros = 0; sat_val = 1'b1;
    pulse_start(26'h3000000, 2'b01, s);
    wait_done(100, dc);
    n_chk++;
    if (sat !== 1'b1 || locked !== 1'b1) begin
      n_err++; $display("FAIL sat_set: got sat %b locked %b expected 1 1", sat, locked);
    end
    repeat (2) @(negedge clk);
    lock_base = lock_reads; sat_val = 1'b0;
    pulse_start(26'h3000000, 2'b01, s);
    n_chk++;
    if (sat !== 1'b0 || locked !== 1'b0 || timeout !== 1'b0) begin
      n_err++; $display("FAIL sat_clear_on_start: got sat %b locked %b timeout %b expected 0 0 0", sat, locked, timeout);
    end
    wait_done(100, dc);
    n_chk++;
    if (sat !== 1'b0 || locked !== 1'b1) begin
      n_err++; $display("FAIL sat_second: got sat %b locked %b expected 0 1", sat, locked);
    end
  endtask

  task automatic test_abort();
    int s, base, d0, v0, n_en;
    lock_base = lock_reads; lock_zeros = 0;
    base = n_log; d0 = n_done; n_en = 0;
    pulse_start(26'h0ABCDEF, 2'b11, s);
    while (cyc < s + 8) begin @(negedge clk); #1; end
    n_chk++;
    if (m_valid !== 1'b1 || m_ready !== 1'b1 || m_address !== ADPLL_MODE) begin
      n_err++; $display("FAIL abort_setup: got valid %b ready %b addr %0h expected 1 1 2", m_valid, m_ready, m_address);
    end
    abort = 1'b1;
    @(negedge clk); #1;
    abort = 1'b0;
    v0 = n_valid;
    n_chk++;
    if (busy !== 1'b0 || m_valid !== 1'b0) begin
      n_err++; $display("FAIL abort_idle: got busy %b valid %b expected 0 0", busy, m_valid);
    end
    repeat (30) @(negedge clk);
    #1;
    for (int k = base; k < n_log; k++) if (log_addr[k] == ADPLL_EN) n_en++;
    n_chk++;
    if (n_done != d0 || n_en != 0 || n_valid != v0) begin
      n_err++; $display("FAIL abort_quiet: got done %0d en_writes %0d valid_cycles %0d expected 0 0 0",
                        n_done - d0, n_en, n_valid - v0);
    end
  endtask

  task automatic test_slow_ready();
    int s, dc, base, f0, u0;
    lock_base = lock_reads; lock_zeros = 0; sat_val = 1'b0; fcw_slow = 1'b1;
    base = n_log; f0 = n_fcw_valid; u0 = n_unstable;
    pulse_start(26'h3FFFFFF, 2'b10, s);
    wait_done(100, dc);
    fcw_slow = 1'b0;
    n_chk++;
    if (n_fcw_valid - f0 != 6 || n_unstable != u0) begin
      n_err++; $display("FAIL slow_hold: got valid_cycles %0d unstable %0d expected 6 0", n_fcw_valid - f0, n_unstable - u0);
    end
    n_chk++;
    if (dc - s != 23 || locked !== 1'b1) begin
      n_err++; $display("FAIL slow_done: got cyc %0d locked %b expected 23 1", dc - s, locked);
    end
    n_chk++;
    if (n_log - base != 6 || log_wdata[base+1] !== 32'h03FFFFFF || log_wdata[base+2] !== 32'd2) begin
      n_err++; $display("FAIL slow_data: got n %0d fcw %0h mode %0h expected 6 3ffffff 2",
                        n_log - base, log_wdata[base+1], log_wdata[base+2]);
    end
  endtask

  task automatic test_reset_mid();
    int s, v0, l0;
    pulse_start(26'h0000ABC, 2'b01, s);
    rst = 1'b1;
    #1;
    n_chk++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || m_address !== 5'd0) begin
      n_err++; $display("FAIL reset_mid: got valid %b busy %b addr %0h expected 0 0 0", m_valid, busy, m_address);
    end
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    v0 = n_valid; l0 = n_log;
    repeat (15) @(negedge clk);
    #1;
    n_chk++;
    if (n_valid != v0 || n_log != l0 || busy !== 1'b0) begin
      n_err++; $display("FAIL reset_no_retry: got valid_cycles %0d txns %0d busy %b expected 0 0 0",
                        n_valid - v0, n_log - l0, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_poll_retry();
    test_timeout();
    test_sat();
    test_abort();
    test_slow_ready();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
